pid_pos_axi_regs: RTL and testbench
===================================

PID_POS_AXI_REGS -- requirements
Module: pid_pos_axi_regs

Interface
REQ-001 Parameter NUM_CH, default 2: number of PID position channels, legal range 1..4.
REQ-002 Parameter GAIN_W, default 16: width of Kp/Ki/Kd, legal range 8..32.
REQ-003 Parameter POS_W, default 32: width of position values, legal range 16..32.
REQ-004 Parameter C_S_AXI_DATA_WIDTH, default 32, fixed at 32; C_S_AXI_ADDR_WIDTH = clog2(NUM_CH)+5 (derived, not overridable).
REQ-005 s00_axi_aclk  in  1  sole clock; s00_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-006 s00_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave set with standard widths; awprot/arprot are ignored.
REQ-007 kp_o, ki_o, kd_o  out  NUM_CH*GAIN_W  active gains, channel c in slice [c*GAIN_W +: GAIN_W].
REQ-008 desired_pos_o  out  NUM_CH*POS_W  active target positions; actual_pos_i  in  NUM_CH*POS_W  measured positions.
REQ-009 enable_o  out  NUM_CH  per-channel loop enable; commit_o  out  NUM_CH  one-cycle pulse per channel commit.

Function
REQ-010 Channel c occupies the window c*0x20: 0x00 KP, 0x04 KI, 0x08 KD, 0x0C DESIRED (RW shadow); 0x10 ACTUAL (RO); 0x14 CTRL; 0x18 STATUS (RO); 0x1C ERROR (RO).
REQ-011 CTRL: bit0 ENABLE is RW and takes effect on enable_o immediately; bit1 COMMIT is write-1, self-clearing, and reads 0.
REQ-012 Writes to 0x00-0x0C update shadow registers only; active outputs are unchanged until that channel commits.
REQ-013 Commit accepted at edge T: active gains and desired positions equal the shadow values from T+1; commit_o[c] is high for exactly one cycle, T+1.
REQ-014 STATUS bit0 PENDING is set by any shadow write and cleared by a commit; a commit and a shadow write cannot coincide on the single write channel.
REQ-015 The slave honours WSTRB per byte on RW registers; shadow bits above GAIN_W/POS_W are not stored and read 0; DESIRED and ACTUAL are sign-extended to 32 bits on read.
REQ-016 Write handshake: awready and wready pulse together for one cycle when awvalid && wvalid && !bvalid; bvalid rises the next cycle and holds until bready; bresp = OKAY.
REQ-017 Read handshake: arready pulses for one cycle when arvalid && !rvalid; rdata is registered; rvalid rises the next cycle and holds with stable rdata until rready; rresp = OKAY.
REQ-018 Read and write may proceed in the same cycle; a read of a register being written that cycle returns the old value.
REQ-019 For a channel index >= NUM_CH or an unmapped offset, the slave ignores writes, returns 0 on reads, and still responds OKAY.
REQ-020 actual_pos_i is registered one stage; ACTUAL reads return the registered value.

Reset
REQ-021 While s00_axi_aresetn=0 at a clock edge, the block clears all shadow and active registers, enable_o, commit_o, PENDING, awready, wready, arready, bvalid, rvalid and rdata to 0.
REQ-022 Reset mid-transaction abandons the transaction; no bvalid or rvalid is issued for it after reset is released.

Configuration
REQ-023 Macro PID_POS_ERR_READBACK_EN defined: ERROR = active desired - registered actual, signed POS_W+1 bits, registered, sign-extended/saturated to 32 bits.
REQ-024 Macro PID_POS_ERR_READBACK_EN undefined: the block omits the subtractor; offset 0x1C reads 0.

Structure
REQ-025 Package pid_pos_regs_pkg holds register offsets, channel stride 0x20, CTRL/STATUS bit indices, and the OKAY response constant.
REQ-026 Sub-module pid_pos_ch_regs holds one channel's shadow, active, CTRL and PENDING state; the top instantiates it NUM_CH times through a generate loop and owns the AXI FSMs and read mux.

Verification
REQ-027 Reset, then read every register of every channel -> all reads return 0x00000000; enable_o=0; all outputs 0.
REQ-028 Write ch1 KP=0x1234, read it back -> readback 0x1234; kp_o ch1 slice stays 0; PENDING=1; then write CTRL=0x2 -> kp_o ch1=0x1234 at T+1; commit_o[1] pulses once; PENDING=0; CTRL reads 0.
REQ-029 Write DESIRED with WSTRB=0b0011, data 0xAAAA5555, over prior 0xFFFFFFFF -> readback 0xFFFF5555.
REQ-030 Hold bready=0 for 5 cycles after a write -> bvalid stays high; awready stays 0 for a second pending write until bready.
REQ-031 actual_pos_i ch0=-100, desired ch0 committed at 50 -> ACTUAL reads 0xFFFFFF9C; with the macro, ERROR reads 150; without it, ERROR reads 0.
REQ-032 Write to channel index NUM_CH -> OKAY response; no output changes; read of that address returns 0.

Source files
------------

// File: rtl/pid_pos_regs_pkg.sv
// rtl/pid_pos_regs_pkg.sv - register map, handshake states and helpers for pid_pos_axi_regs
package pid_pos_regs_pkg;

    // Per-channel register offsets (byte addresses inside a channel window)
    localparam logic [4:0] OFF_KP      = 5'h00;
    localparam logic [4:0] OFF_KI      = 5'h04;
    localparam logic [4:0] OFF_KD      = 5'h08;
    localparam logic [4:0] OFF_DESIRED = 5'h0C;
    localparam logic [4:0] OFF_ACTUAL  = 5'h10;
    localparam logic [4:0] OFF_CTRL    = 5'h14;
    localparam logic [4:0] OFF_STATUS  = 5'h18;
    localparam logic [4:0] OFF_ERROR   = 5'h1C;

    localparam int CH_STRIDE = 32'h20;
    localparam int CH_SHIFT  = $clog2(CH_STRIDE);

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_COMMIT_BIT    = 1;
    localparam int STATUS_PENDING_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

    // Byte-lane merge of a write into the previous register contents
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return r;
    endfunction

    // Clamp a 33-bit signed value into the 32-bit signed range
    function automatic logic [31:0] sat_to_32(input logic signed [32:0] v);
        if (v[32] != v[31])
            return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return v[31:0];
    endfunction

endpackage

// File: rtl/pid_pos_ch_regs.sv
// rtl/pid_pos_ch_regs.sv - one PID channel: shadow/active gains and target, CTRL, PENDING
// Ports: clk/resetn; wr_en/wr_off/wdata/wstrb write port from the bus slave;
// sh_* shadow values for readback; kp/ki/kd/desired active values;
// enable (CTRL.ENABLE), pending (STATUS.PENDING), commit (one-cycle pulse).
module pid_pos_ch_regs
    import pid_pos_regs_pkg::*;
#(
    parameter int GAIN_W = 16,
    parameter int POS_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [4:0]        wr_off,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [GAIN_W-1:0] sh_kp,
    output logic [GAIN_W-1:0] sh_ki,
    output logic [GAIN_W-1:0] sh_kd,
    output logic [POS_W-1:0]  sh_desired,
    output logic [GAIN_W-1:0] kp,
    output logic [GAIN_W-1:0] ki,
    output logic [GAIN_W-1:0] kd,
    output logic [POS_W-1:0]  desired,
    output logic              enable,
    output logic              pending,
    output logic              commit
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_kp      <= '0;
            sh_ki      <= '0;
            sh_kd      <= '0;
            sh_desired <= '0;
            kp         <= '0;
            ki         <= '0;
            kd         <= '0;
            desired    <= '0;
            enable     <= 1'b0;
            pending    <= 1'b0;
            commit     <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (wr_en) begin
                case (wr_off)
                    OFF_KP: begin
                        sh_kp   <= GAIN_W'(apply_wstrb(32'(sh_kp), wdata, wstrb));
                        pending <= 1'b1;
                    end
                    OFF_KI: begin
                        sh_ki   <= GAIN_W'(apply_wstrb(32'(sh_ki), wdata, wstrb));
                        pending <= 1'b1;
                    end
                    OFF_KD: begin
                        sh_kd   <= GAIN_W'(apply_wstrb(32'(sh_kd), wdata, wstrb));
                        pending <= 1'b1;
                    end
                    OFF_DESIRED: begin
                        sh_desired <= POS_W'(apply_wstrb(32'(sh_desired), wdata, wstrb));
                        pending    <= 1'b1;
                    end
                    OFF_CTRL: begin
                        // ENABLE and COMMIT both live in byte lane 0
                        if (wstrb[0]) begin
                            enable <= wdata[CTRL_ENABLE_BIT];
                            if (wdata[CTRL_COMMIT_BIT]) begin
                                kp      <= sh_kp;
                                ki      <= sh_ki;
                                kd      <= sh_kd;
                                desired <= sh_desired;
                                pending <= 1'b0;
                                commit  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pid_pos_axi_regs.sv
// rtl/pid_pos_axi_regs.sv - AXI4-Lite register bank for NUM_CH PID position channels
// Ports: s00_axi_* AXI4-Lite slave (aclk, sync active-low aresetn); kp_o/ki_o/kd_o/desired_o
// active per-channel values; actual_pos_i measured positions; enable_o per-channel enable;
// commit_o per-channel commit pulse. Optional macro PID_POS_ERR_READBACK_EN adds the
// registered ERROR readback (active desired - registered actual).
module pid_pos_axi_regs
    import pid_pos_regs_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int GAIN_W             = 16,
    parameter int POS_W              = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    localparam int C_S_AXI_ADDR_WIDTH = $clog2(NUM_CH) + 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH*GAIN_W-1:0]        kp_o,
    output logic [NUM_CH*GAIN_W-1:0]        ki_o,
    output logic [NUM_CH*GAIN_W-1:0]        kd_o,
    output logic [NUM_CH*POS_W-1:0]         desired_o,
    input  logic [NUM_CH*POS_W-1:0]         actual_pos_i,
    output logic [NUM_CH-1:0]               enable_o,
    output logic [NUM_CH-1:0]               commit_o
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic        wr_fire;
    logic [AW-1:0] wr_ch;
    logic [AW-1:0] rd_ch;
    logic [4:0]  wr_off;
    logic [4:0]  rd_off;
    logic [31:0] rd_mux;
    logic [31:0] ch_rd [NUM_CH];
    logic [NUM_CH-1:0] ch_pending;
    logic        unused_inputs;

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Address and data are consumed on the edge that completes the AW/W handshake
    assign wr_fire = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
    assign wr_ch   = s00_axi_awaddr >> CH_SHIFT;
    assign rd_ch   = s00_axi_araddr >> CH_SHIFT;
    assign wr_off  = {s00_axi_awaddr[4:2], 2'b00};
    assign rd_off  = {s00_axi_araddr[4:2], 2'b00};

    assign s00_axi_bresp = RESP_OKAY;
    assign s00_axi_rresp = RESP_OKAY;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [GAIN_W-1:0] sh_kp;
        logic [GAIN_W-1:0] sh_ki;
        logic [GAIN_W-1:0] sh_kd;
        logic [POS_W-1:0]  sh_desired;
        logic [POS_W-1:0]  act_q;
        logic [31:0]       err_rd;
        logic [31:0]       rd_val;

        pid_pos_ch_regs #(.GAIN_W(GAIN_W), .POS_W(POS_W)) u_ch (
            .clk        (s00_axi_aclk),
            .resetn     (s00_axi_aresetn),
            .wr_en      (wr_fire && (wr_ch == AW'(c))),
            .wr_off     (wr_off),
            .wdata      (s00_axi_wdata),
            .wstrb      (s00_axi_wstrb),
            .sh_kp      (sh_kp),
            .sh_ki      (sh_ki),
            .sh_kd      (sh_kd),
            .sh_desired (sh_desired),
            .kp         (kp_o[c*GAIN_W +: GAIN_W]),
            .ki         (ki_o[c*GAIN_W +: GAIN_W]),
            .kd         (kd_o[c*GAIN_W +: GAIN_W]),
            .desired    (desired_o[c*POS_W +: POS_W]),
            .enable     (enable_o[c]),
            .pending    (ch_pending[c]),
            .commit     (commit_o[c])
        );

        always_ff @(posedge s00_axi_aclk) begin
            if (!s00_axi_aresetn) act_q <= '0;
            else                  act_q <= actual_pos_i[c*POS_W +: POS_W];
        end

`ifdef PID_POS_ERR_READBACK_EN
        logic signed [POS_W:0] err_q;
        logic [POS_W-1:0]      des_act;
        assign des_act = desired_o[c*POS_W +: POS_W];

        // One extra bit keeps the difference of two POS_W values exact
        always_ff @(posedge s00_axi_aclk) begin
            if (!s00_axi_aresetn) err_q <= '0;
            else err_q <= $signed({des_act[POS_W-1], des_act}) - $signed({act_q[POS_W-1], act_q});
        end
        assign err_rd = sat_to_32(33'(err_q));
`else
        assign err_rd = '0;
`endif

        always_comb begin
            rd_val = '0;
            case (rd_off)
                OFF_KP:      rd_val = 32'(sh_kp);
                OFF_KI:      rd_val = 32'(sh_ki);
                OFF_KD:      rd_val = 32'(sh_kd);
                OFF_DESIRED: rd_val = 32'($signed(sh_desired));
                OFF_ACTUAL:  rd_val = 32'($signed(act_q));
                OFF_CTRL:    rd_val[CTRL_ENABLE_BIT] = enable_o[c];
                OFF_STATUS:  rd_val[STATUS_PENDING_BIT] = ch_pending[c];
                OFF_ERROR:   rd_val = err_rd;
                default:     rd_val = '0;
            endcase
        end
        assign ch_rd[c] = rd_val;
    end

    // Channel indices with no instance fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch == AW'(c)) rd_mux = ch_rd[c];
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wr_state        <= WR_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) begin
                    s00_axi_awready <= 1'b1;
                    s00_axi_wready  <= 1'b1;
                    wr_state        <= WR_ACCEPT;
                end
                WR_ACCEPT: begin
                    s00_axi_awready <= 1'b0;
                    s00_axi_wready  <= 1'b0;
                    s00_axi_bvalid  <= 1'b1;
                    wr_state        <= WR_RESP;
                end
                WR_RESP: if (s00_axi_bready) begin
                    s00_axi_bvalid <= 1'b0;
                    wr_state       <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= RD_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: if (s00_axi_arvalid) begin
                    s00_axi_arready <= 1'b1;
                    rd_state        <= RD_ACCEPT;
                end
                RD_ACCEPT: begin
                    // Sampled before any same-edge write lands, so reads see the old value
                    s00_axi_arready <= 1'b0;
                    s00_axi_rvalid  <= 1'b1;
                    s00_axi_rdata   <= rd_mux;
                    rd_state        <= RD_DATA;
                end
                RD_DATA: if (s00_axi_rready) begin
                    s00_axi_rvalid <= 1'b0;
                    rd_state       <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_pos_axi_regs.sv
// tb/tb_pid_pos_axi_regs.sv - self-checking bench for pid_pos_axi_regs
module tb_pid_pos_axi_regs;
    localparam int NUM_CH = 3;
    localparam int GAIN_W = 16;
    localparam int POS_W  = 24;
    localparam int AW     = $clog2(NUM_CH) + 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NUM_CH*GAIN_W-1:0] kp_o, ki_o, kd_o;
    logic [NUM_CH*POS_W-1:0] desired_o, actual_pos_i;
    logic [NUM_CH-1:0] enable_o, commit_o;

    pid_pos_axi_regs #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .POS_W(POS_W)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(resetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .kp_o(kp_o), .ki_o(ki_o), .kd_o(kd_o),
        .desired_o(desired_o), .actual_pos_i(actual_pos_i), .enable_o(enable_o),
        .commit_o(commit_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: index 0..3 = KP, KI, KD, DESIRED
    logic [31:0] m_sh  [4][NUM_CH];
    logic [31:0] m_act [4][NUM_CH];
    logic        m_en   [NUM_CH];
    logic        m_pend [NUM_CH];
    int          m_commits [NUM_CH];
    int          seen_commits [NUM_CH];

    logic [NUM_CH*GAIN_W-1:0] wr_pre_kp, wr_post_kp;
    logic [NUM_CH-1:0]        wr_post_commit;

    initial for (int c = 0; c < NUM_CH; c++) seen_commits[c] = 0;
    always @(posedge clk)
        for (int c = 0; c < NUM_CH; c++) if (commit_o[c] === 1'b1) seen_commits[c]++;

    function automatic logic [31:0] mask_w(int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] sext(logic [31:0] v);
        return v[POS_W-1] ? (v | ~mask_w(POS_W)) : (v & mask_w(POS_W));
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < 4; i++) begin m_sh[i][c] = 0; m_act[i][c] = 0; end
            m_en[c] = 0; m_pend[c] = 0; m_commits[c] = 0;
        end
    endfunction

    function automatic void model_write(logic [AW-1:0] addr, logic [31:0] d, logic [3:0] s);
        int ch, off, idx;
        ch = int'(addr) / 32; off = int'(addr) % 32; off = off - off % 4;
        if (ch >= NUM_CH) return;
        if (off <= 12) begin
            idx = off / 4;
            for (int b = 0; b < 4; b++) if (s[b]) m_sh[idx][ch][b*8 +: 8] = d[b*8 +: 8];
            m_sh[idx][ch] &= mask_w(idx == 3 ? POS_W : GAIN_W);
            m_pend[ch] = 1;
        end else if (off == 20 && s[0]) begin
            m_en[ch] = d[0];
            if (d[1]) begin
                for (int i = 0; i < 4; i++) m_act[i][ch] = m_sh[i][ch];
                m_pend[ch] = 0;
                m_commits[ch]++;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(logic [AW-1:0] addr);
        int ch, off;
        longint diff;
        ch = int'(addr) / 32; off = int'(addr) % 32; off = off - off % 4;
        if (ch >= NUM_CH) return 0;
        case (off)
            0, 4, 8: return m_sh[off/4][ch];
            12: return sext(m_sh[3][ch]);
            16: return sext(32'(actual_pos_i[ch*POS_W +: POS_W]));
            20: return {31'd0, m_en[ch]};
            24: return {31'd0, m_pend[ch]};
            default: begin
`ifdef PID_POS_ERR_READBACK_EN
                diff = longint'($signed(sext(m_act[3][ch])))
                     - longint'($signed(sext(32'(actual_pos_i[ch*POS_W +: POS_W]))));
                if (diff > 64'sd2147483647) diff = 64'sd2147483647;
                if (diff < -64'sd2147483648) diff = -64'sd2147483648;
                return diff[31:0];
`else
                diff = 0;
                return diff[31:0];
`endif
            end
        endcase
    endfunction

    function automatic logic [NUM_CH*GAIN_W-1:0] exp_gain(int idx);
        logic [NUM_CH*GAIN_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*GAIN_W +: GAIN_W] = m_act[idx][c][GAIN_W-1:0];
        return v;
    endfunction

    function automatic logic [NUM_CH*POS_W-1:0] exp_des();
        logic [NUM_CH*POS_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*POS_W +: POS_W] = m_act[3][c][POS_W-1:0];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_en();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_en[c];
        return v;
    endfunction

    // Bus tasks: entered and left at #1 after a rising edge
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (awready !== 1'b1) begin
            n_fail++; $display("FAIL write_timeout: awready got %b expected 1", awready);
        end
        wr_pre_kp = kp_o;
        @(posedge clk); #1;
        wr_post_kp = kp_o; wr_post_commit = commit_o;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (bvalid !== 1'b1) begin
            n_fail++; $display("FAIL bvalid_timeout: bvalid got %b expected 1", bvalid);
        end
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1; rready = 1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (arready !== 1'b1) begin
            n_fail++; $display("FAIL read_timeout: arready got %b expected 1", arready);
        end
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rvalid_timeout: rvalid got %b expected 1", rvalid);
        end
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        model_reset();
        n_cmp++;
        if (kp_o !== '0 || ki_o !== '0 || kd_o !== '0 || desired_o !== '0 || enable_o !== '0 || commit_o !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got kp=%h en=%b commit=%b expected 0", kp_o, enable_o, commit_o);
        end
        n_cmp++;
        if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 || rdata !== 0) begin
            n_fail++; $display("FAIL reset_bus: got awr=%b bv=%b rv=%b rdata=%h expected 0", awready, bvalid, rvalid, rdata);
        end
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 8; o++) begin
                axi_read(AW'(c*32 + o*4), d, r);
                n_cmp++;
                if (d !== 32'h0 || r !== 2'b00) begin
                    n_fail++; $display("FAIL reset_read ch%0d off%0h: got %h/%b expected 00000000/00", c, o*4, d, r);
                end
            end
    endtask

    task automatic test_commit();
        logic [31:0] d; logic [1:0] r; int base;
        base = seen_commits[1];
        axi_write(AW'(32 + 0), 32'h1234, 4'hF, r); model_write(AW'(32), 32'h1234, 4'hF);
        n_cmp++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL commit_bresp: got %b expected 00", r); end
        axi_read(AW'(32), d, r);
        n_cmp++;
        if (d !== 32'h1234) begin n_fail++; $display("FAIL kp_readback: got %h expected 00001234", d); end
        n_cmp++;
        if (kp_o[GAIN_W +: GAIN_W] !== '0) begin n_fail++; $display("FAIL kp_shadow_only: got %h expected 0", kp_o[GAIN_W +: GAIN_W]); end
        axi_read(AW'(32 + 24), d, r);
        n_cmp++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL pending_set: got %h expected 00000001", d); end
        axi_write(AW'(32 + 20), 32'h2, 4'hF, r); model_write(AW'(32 + 20), 32'h2, 4'hF);
        n_cmp++;
        if (wr_pre_kp[GAIN_W +: GAIN_W] !== '0) begin n_fail++; $display("FAIL kp_before_commit: got %h expected 0", wr_pre_kp[GAIN_W +: GAIN_W]); end
        n_cmp++;
        if (wr_post_kp[GAIN_W +: GAIN_W] !== 16'h1234 || wr_post_commit !== 3'b010) begin
            n_fail++; $display("FAIL commit_t1: got kp=%h commit=%b expected 1234/010", wr_post_kp[GAIN_W +: GAIN_W], wr_post_commit);
        end
        n_cmp++;
        if (seen_commits[1] - base !== 1) begin n_fail++; $display("FAIL commit_pulses: got %0d expected 1", seen_commits[1] - base); end
        axi_read(AW'(32 + 24), d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL pending_clear: got %h expected 00000000", d); end
        axi_read(AW'(32 + 20), d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_reads0: got %h expected 00000000", d); end
    endtask

    task automatic test_wstrb();
        logic [31:0] d; logic [1:0] r;
        axi_write(AW'(12), 32'hFFFF_FFFF, 4'hF, r); model_write(AW'(12), 32'hFFFF_FFFF, 4'hF);
        axi_write(AW'(12), 32'hAAAA_5555, 4'b0011, r); model_write(AW'(12), 32'hAAAA_5555, 4'b0011);
        axi_read(AW'(12), d, r);
        n_cmp++;
        if (d !== 32'hFFFF_5555) begin n_fail++; $display("FAIL wstrb_desired: got %h expected ffff5555", d); end
        axi_write(AW'(4), 32'hDEAD_BEEF, 4'hF, r); model_write(AW'(4), 32'hDEAD_BEEF, 4'hF);
        axi_read(AW'(4), d, r);
        n_cmp++;
        if (d !== 32'h0000_BEEF) begin n_fail++; $display("FAIL gain_width: got %h expected 0000beef", d); end
    endtask

    task automatic test_bready_hold();
        logic [31:0] d; logic [1:0] r; int n;
        awaddr = AW'(64 + 8); wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; model_write(AW'(64 + 8), 32'h77, 4'hF);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bvalid !== 1'b1) begin n_fail++; $display("FAIL bvalid_hold cyc%0d: got %b expected 1", i, bvalid); end
            @(posedge clk); #1;
            if (i == 1) begin awaddr = AW'(64 + 4); wdata = 32'h0000_0099; awvalid = 1; wvalid = 1; end
        end
        n_cmp++;
        if (awready !== 1'b0) begin n_fail++; $display("FAIL second_aw_blocked: got %b expected 0", awready); end
        bready = 1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (awready !== 1'b1) begin n_fail++; $display("FAIL second_aw_accept: got %b expected 1", awready); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; model_write(AW'(64 + 4), 32'h99, 4'hF);
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bready = 0;
        axi_read(AW'(64 + 4), d, r);
        n_cmp++;
        if (d !== model_read(AW'(64 + 4))) begin n_fail++; $display("FAIL second_write_data: got %h expected %h", d, model_read(AW'(64 + 4))); end
    endtask

    task automatic test_actual_error();
        logic [31:0] d; logic [1:0] r;
        actual_pos_i[0 +: POS_W] = POS_W'(-100);
        axi_write(AW'(12), 32'd50, 4'hF, r); model_write(AW'(12), 32'd50, 4'hF);
        axi_write(AW'(20), 32'h2, 4'hF, r); model_write(AW'(20), 32'h2, 4'hF);
        repeat (3) @(posedge clk); #1;
        axi_read(AW'(16), d, r);
        n_cmp++;
        if (d !== 32'hFFFF_FF9C) begin n_fail++; $display("FAIL actual_read: got %h expected ffffff9c", d); end
        axi_read(AW'(28), d, r);
        n_cmp++;
`ifdef PID_POS_ERR_READBACK_EN
        if (d !== 32'd150) begin n_fail++; $display("FAIL error_read: got %h expected 00000096", d); end
`else
        if (d !== 32'd0) begin n_fail++; $display("FAIL error_read: got %h expected 00000000", d); end
`endif
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r;
        for (int o = 0; o < 6; o++) begin
            axi_write(AW'(NUM_CH*32 + o*4), 32'hFFFF_FFFF, 4'hF, r);
            n_cmp++;
            if (r !== 2'b00) begin n_fail++; $display("FAIL unmapped_bresp off%0h: got %b expected 00", o*4, r); end
        end
        n_cmp++;
        if (kp_o !== exp_gain(0) || desired_o !== exp_des() || enable_o !== exp_en()) begin
            n_fail++; $display("FAIL unmapped_outputs: got kp=%h en=%b expected kp=%h en=%b", kp_o, enable_o, exp_gain(0), exp_en());
        end
        axi_read(AW'(NUM_CH*32), d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL unmapped_read: got %h/%b expected 00000000/00", d, r); end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d; logic [1:0] r, r2;
        axi_write(AW'(64 + 4), 32'h1111, 4'hF, r); model_write(AW'(64 + 4), 32'h1111, 4'hF);
        fork
            axi_write(AW'(64 + 4), 32'h2222, 4'hF, r2);
            axi_read(AW'(64 + 4), d, r);
        join
        n_cmp++;
        if (d !== 32'h1111) begin n_fail++; $display("FAIL rw_old_value: got %h expected 00001111", d); end
        model_write(AW'(64 + 4), 32'h2222, 4'hF);
        axi_read(AW'(64 + 4), d, r);
        n_cmp++;
        if (d !== 32'h2222) begin n_fail++; $display("FAIL rw_new_value: got %h expected 00002222", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, x; logic [1:0] r; logic [AW-1:0] a; logic [3:0] s;
        int base [NUM_CH];
        for (int c = 0; c < NUM_CH; c++) begin
            actual_pos_i[c*POS_W +: POS_W] = POS_W'($urandom);
            base[c] = seen_commits[c] - m_commits[c];
        end
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 80; i++) begin
            a = AW'($urandom_range(0, NUM_CH) * 32 + $urandom_range(0, 7) * 4);
            x = $urandom; s = 4'($urandom);
            axi_write(a, x, s, r); model_write(a, x, s);
            n_cmp++;
            if (r !== 2'b00 || kp_o !== exp_gain(0) || ki_o !== exp_gain(1) || kd_o !== exp_gain(2)
                || desired_o !== exp_des() || enable_o !== exp_en()) begin
                n_fail++; $display("FAIL rand_outputs it%0d: got kp=%h des=%h en=%b expected kp=%h des=%h en=%b",
                                   i, kp_o, desired_o, enable_o, exp_gain(0), exp_des(), exp_en());
            end
            a = AW'($urandom_range(0, NUM_CH) * 32 + $urandom_range(0, 7) * 4);
            axi_read(a, d, r);
            n_cmp++;
            if (d !== model_read(a)) begin n_fail++; $display("FAIL rand_read it%0d addr %h: got %h expected %h", i, a, d, model_read(a)); end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            n_cmp++;
            if (seen_commits[c] - base[c] !== m_commits[c]) begin
                n_fail++; $display("FAIL rand_commits ch%0d: got %0d expected %0d", c, seen_commits[c] - base[c], m_commits[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int n;
        awaddr = AW'(32); wdata = 32'h5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        araddr = AW'(0); arvalid = 1; rready = 1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        resetn = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(posedge clk); #1;
        resetn = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bvalid !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_abandon cyc%0d: got bv=%b rv=%b expected 0/0", i, bvalid, rvalid); end
            @(posedge clk); #1;
        end
        bready = 0; rready = 0;
        axi_read(AW'(32), d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mid_kp: got %h expected 00000000", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; actual_pos_i = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        test_reset();
        test_commit();
        test_wstrb();
        test_bready_hold();
        test_actual_error();
        test_unmapped();
        test_rw_same_cycle();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
